// File: rtl/wb_unit_pkg.sv
// Shared core definitions for the writeback unit: register/data widths and
// the result-channel request record.
package wb_unit_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_unit_arb.sv
// Two-way aging arbiter: LSU has priority, but an ALU result that has lost
// AGE_LIMIT consecutive cycles is promoted above it.
module wb_arb #(
  parameter int AGE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       alu_valid_i,
  input  logic       lsu_valid_i,
  output logic       alu_gnt_o,
  output logic       lsu_gnt_o,
  output logic [7:0] age_cnt_o
);
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q, age_d;
  logic             promote;

  assign promote = (age_q == AGE_W'(AGE_LIMIT));

  // Grants are forced low in reset so nothing is accepted while the
  // output register is held clear.
  assign alu_gnt_o = rst_ni & alu_valid_i & (~lsu_valid_i | promote);
  assign lsu_gnt_o = rst_ni & lsu_valid_i & ~(alu_valid_i & promote);
  assign age_cnt_o = 8'(age_q);

  always_comb begin
    age_d = age_q;
    if (alu_gnt_o)
      age_d = '0;
    else if (alu_valid_i && !promote)
      age_d = age_q + AGE_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) age_q <= '0;
    else         age_q <= age_d;
  end
endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU and LSU results onto one register-file write
// port and tracks pending destinations in a busy scoreboard.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alu_valid_i,
  input  logic [REG_W-1:0]  alu_rd_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [REG_W-1:0]  lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_ready_o,
  input  logic              issue_valid_i,
  input  logic [REG_W-1:0]  issue_rd_i,
  input  logic              flush_i,
  output logic [REG_W-1:0]  reg_dst_o,
  output logic              reg_wen_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [NUM_REGS-1:0] busy_o
);
  // Handshake: a result moves on a rising edge where valid && ready. ready is
  // combinational, at most one channel sees it, and a producer left waiting
  // keeps its payload stable since nothing is buffered here.
  wb_req_t alu_req, lsu_req, win_req;
  logic    alu_gnt, lsu_gnt, xfer;
  logic [7:0] age_cnt;

  logic                wen_q, wen_d;
  logic [REG_W-1:0]    dst_q, dst_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign alu_req = {alu_valid_i, alu_rd_i, alu_wdata_i};
  assign lsu_req = {lsu_valid_i, lsu_rd_i, lsu_wdata_i};

  wb_arb #(.AGE_LIMIT(AGE_LIMIT)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alu_valid_i (alu_req.valid),
    .lsu_valid_i (lsu_req.valid),
    .alu_gnt_o   (alu_gnt),
    .lsu_gnt_o   (lsu_gnt),
    .age_cnt_o   (age_cnt)
  );

  assign win_req = alu_gnt ? alu_req : lsu_req;
  assign xfer    = (alu_gnt | lsu_gnt) & win_req.valid;

  always_comb begin
    wen_d   = 1'b0;
    dst_d   = dst_q;
    wdata_d = wdata_q;
    if (xfer) begin
      wen_d   = (win_req.rd != '0);
      dst_d   = win_req.rd;
      wdata_d = win_req.wdata;
    end
  end

  // Set is applied after clear so a reissued rd stays pending; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (xfer)          busy_d = busy_d & ~rd_onehot(win_req.rd);
    if (issue_valid_i) busy_d = busy_d | rd_onehot(issue_rd_i);
    if (flush_i)       busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wen_q   <= 1'b0;
      dst_q   <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      dst_q   <= dst_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign alu_ready_o = alu_gnt;
  assign lsu_ready_o = lsu_gnt;
  assign reg_wen_o   = wen_q;
  assign reg_dst_o   = dst_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;

  logic unused_age;
  assign unused_age = ^age_cnt;
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit with a cycle model feeding an expected-write queue.
module tb_wb_unit;
  localparam int AGE_LIMIT = 4;

  logic        clk, rst_ni;
  logic        alu_valid, lsu_valid, issue_valid, flush;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        alu_ready, lsu_ready, reg_wen;
  logic [4:0]  reg_dst;
  logic [31:0] reg_wdata, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [37:0] exp_q[$];

  int          m_age;
  logic [31:0] m_busy;
  logic [4:0]  m_dst;
  logic [31:0] m_data;
  logic        m_alu_rdy, m_lsu_rdy, m_alu_won;

  wb_unit #(.AGE_LIMIT(AGE_LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_wdata_i(alu_wdata), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .flush_i(flush),
    .reg_dst_o(reg_dst), .reg_wen_o(reg_wen), .reg_wdata_o(reg_wdata), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_age = 0; m_busy = '0; m_dst = '0; m_data = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, check ready, advance one edge, check outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                      input logic iv, input logic [4:0] ird, input logic fl);
    logic [37:0] e;
    logic        wen;
    alu_valid = av; alu_rd = ard; alu_wdata = awd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wdata = lwd;
    issue_valid = iv; issue_rd = ird; flush = fl;
    #1;
    m_alu_rdy = av && (!lv || m_age == AGE_LIMIT);
    m_lsu_rdy = lv && !m_alu_rdy;
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, m_alu_rdy});
    chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, m_lsu_rdy});
    chk("ready_onehot", {31'b0, alu_ready & lsu_ready}, 32'd0);
    @(posedge clk);
    m_alu_won = m_alu_rdy;
    wen = 1'b0;
    if (m_alu_rdy) m_age = 0;
    else if (av && m_age < AGE_LIMIT) m_age++;
    if (m_alu_rdy || m_lsu_rdy) begin
      m_dst  = m_alu_rdy ? ard : lrd;
      m_data = m_alu_rdy ? awd : lwd;
      wen    = (m_dst != 5'd0);
      m_busy[m_dst] = 1'b0;
    end
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    if (fl) m_busy = '0;
    m_busy[0] = 1'b0;
    exp_q.push_back({wen, m_dst, m_data});
    #1;
    e = exp_q.pop_front();
    chk("reg_wen", {31'b0, reg_wen}, {31'b0, e[37]});
    chk("reg_dst", {27'b0, reg_dst}, {27'b0, e[36:32]});
    chk("reg_wdata", reg_wdata, e[31:0]);
    chk("busy", busy, m_busy);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] a_wd;
    logic [13:0] win_mask;
    // Reset with both channels requesting: nothing may be accepted.
    rst_ni = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wdata = 32'h1111_1111;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_wdata = 32'h2222_2222;
    issue_valid = 1'b1; issue_rd = 5'd9; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    chk("rst_reg_wen", {31'b0, reg_wen}, 32'd0);
    chk("rst_reg_dst", {27'b0, reg_dst}, 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    chk("rst_busy", busy, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // First edge after release carries a transfer; also issue rd=5.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 5'd5, 1'b0);
    chk("issue_busy5_set", {31'b0, busy[5]}, 32'd1);
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    chk("single_wen", {31'b0, reg_wen}, 32'd1);
    chk("single_dst", {27'b0, reg_dst}, 32'd5);
    chk("single_wdata", reg_wdata, 32'hDEAD_BEEF);
    chk("single_busy5_clr", {31'b0, busy[5]}, 32'd0);
    idle();
    chk("idle_wen_low", {31'b0, reg_wen}, 32'd0);
    chk("idle_wdata_hold", reg_wdata, 32'hDEAD_BEEF);

    // Continuous contention: ALU holds payload until it wins.
    a_wd = $urandom;
    win_mask = '0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 5'd20, a_wd, 1'b1, 5'(i + 1), $urandom, 1'b0, 5'd0, 1'b0);
      if (m_alu_won) begin
        win_mask[i] = 1'b1;
        a_wd = $urandom;
      end
    end
    chk("contention_pattern", {18'b0, win_mask}, 32'h0000_0210);

    // Write to x0 is accepted but not written.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0);
    chk("x0_wen", {31'b0, reg_wen}, 32'd0);
    chk("x0_busy", busy, 32'd0);

    // Same-edge set and clear of rd=7: set wins.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd7, 1'b0);
    chk("collision_busy7", {31'b0, busy[7]}, 32'd1);

    // Build 0xF0 then flush alongside an issue of rd=3.
    for (int r = 4; r < 7; r++)
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0);
    chk("pre_flush_busy", busy, 32'h0000_00F0);
    step(1'b1, 5'd6, 32'h6666_6666, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1);
    chk("flush_busy", busy, 32'd0);
    chk("flush_keeps_write", {31'b0, reg_wen}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 9) == 0));

    // Async reset between edges right after a transfer.
    idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0);
    step(1'b1, 5'd12, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 1'b0);
    chk("pre_rst_wen", {31'b0, reg_wen}, 32'd1);
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("async_rst_wen", {31'b0, reg_wen}, 32'd0);
    chk("async_rst_busy", busy, 32'd0);
    chk("async_rst_ready", {30'b0, alu_ready, lsu_ready}, 32'd0);
    repeat (2) @(posedge clk);
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    idle();
    chk("post_rst_no_pulse", {31'b0, reg_wen}, 32'd0);
    step(1'b1, 5'd2, 32'h0000_00A2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    chk("post_rst_write", reg_wdata, 32'h0000_00A2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
